// File: rtl/emmc_dev_cmd_responder.sv
// Device-side eMMC CMD line endpoint: receives 48-bit host commands, hands
// index/argument to a card model and serialises an R1/R3 response after N_CR.
module emmc_dev_cmd_responder #(
    parameter int unsigned NCR_MIN = 2,
    parameter int unsigned NCR_MAX = 64
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_idx_o,
    output logic [31:0] cmd_arg_o,
    output logic        err_o,
    output logic        rsp_ready_o,
    input  logic        rsp_valid_i,
    input  logic [1:0]  rsp_type_i,
    input  logic [31:0] rsp_arg_i,
    output logic        timeout_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWaitRsp,
        StSend
    } state_e;

    localparam logic [7:0] NcrMin = 8'(NCR_MIN);
    localparam logic [6:0] NcrMax = 7'(NCR_MAX);

    // One CRC7 (x^7 + x^3 + 1) shift step.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // CRC7 over the first 40 bits of a frame, MSB first, init 0.
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            crc = crc7_step(crc, data[i]);
        end
        return crc;
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  gap_q, gap_d;
    logic [6:0]  crc_q, crc_d;
    logic [44:0] rx_q, rx_d;
    logic [47:0] tx_q, tx_d;
    logic        pending_q, pending_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;

    logic        accept;
    logic        rsp_sends;
    logic        is_r3;
    logic [5:0]  rsp_idx;
    logic [39:0] rsp_body;
    logic [6:0]  rsp_crc;
    logic [47:0] rsp_frame;
    logic [7:0]  gap_next;

    // Response frame assembly from the offered payload.
    always_comb begin
        is_r3     = (rsp_type_i == 2'd2);
        rsp_sends = (rsp_type_i == 2'd1) || is_r3;
        rsp_idx   = is_r3 ? 6'h3f : idx_q;
        rsp_body  = {2'b00, rsp_idx, rsp_arg_i};
        rsp_crc   = is_r3 ? 7'h7f : crc7_calc(rsp_body);
        rsp_frame = {rsp_body, rsp_crc, 1'b1};
    end

    // Handshake and line outputs are decoded from registered state, so an
    // asynchronous reset releases the line at once.
    always_comb begin
        rsp_ready_o = (state_q == StWaitRsp) && !pending_q;
        accept      = rsp_valid_i && rsp_ready_o;
        gap_next    = {1'b0, gap_q} + 8'd1;
        cmd_oe_o    = (state_q == StSend);
        cmd_o       = cmd_oe_o ? tx_q[47] : 1'b1;
        busy_o      = (state_q != StIdle);
        cmd_valid_o = valid_q;
        err_o       = err_q;
        timeout_o   = timeout_q;
        cmd_idx_o   = idx_q;
        cmd_arg_o   = arg_q;
    end

    // Next-state logic for deframing, response wait and serialisation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        crc_d     = crc_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!cmd_i) begin
                    state_d   = StRecv;
                    bit_cnt_d = 6'd1;
                    crc_d     = crc7_step(7'd0, 1'b0);
                end
            end

            StRecv: begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd1 && !cmd_i) begin
                    // Device-to-host direction: not a host command, drop silently.
                    state_d = StIdle;
                end else if (bit_cnt_q == 6'd47) begin
                    if (rx_q[6:0] == crc_q && cmd_i) begin
                        valid_d   = 1'b1;
                        idx_d     = rx_q[44:39];
                        arg_d     = rx_q[38:7];
                        gap_d     = 7'd1;
                        pending_d = 1'b0;
                        state_d   = StWaitRsp;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    if (bit_cnt_q >= 6'd2) begin
                        rx_d = {rx_q[43:0], cmd_i};
                    end
                    if (bit_cnt_q <= 6'd39) begin
                        crc_d = crc7_step(crc_q, cmd_i);
                    end
                end
            end

            StWaitRsp: begin
                if (accept && !rsp_sends) begin
                    state_d = StIdle;
                end else begin
                    if (accept) begin
                        pending_d = 1'b1;
                        tx_d      = rsp_frame;
                    end
                    if ((accept || pending_q) && gap_next >= NcrMin) begin
                        // Start bit goes out in the cycle after this edge.
                        state_d   = StSend;
                        bit_cnt_d = 6'd0;
                    end else if (!(accept || pending_q) && gap_q == NcrMax) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        gap_d = gap_q + 7'd1;
                    end
                end
            end

            StSend: begin
                if (bit_cnt_q == 6'd47) begin
                    pending_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    tx_d      = {tx_q[46:0], 1'b1};
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= StIdle;
            bit_cnt_q <= 6'd0;
            gap_q     <= 7'd0;
            crc_q     <= 7'd0;
            rx_q      <= '0;
            tx_q      <= '1;
            pending_q <= 1'b0;
            idx_q     <= 6'd0;
            arg_q     <= 32'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            crc_q     <= crc_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_emmc_dev_cmd_responder.sv
// Directed bench for emmc_dev_cmd_responder: command deframing, CRC errors,
// R1/R3 responses with N_CR timing, timeout and mid-response reset.
module tb_emmc_dev_cmd_responder;

    localparam int unsigned NcrMin = 4;
    localparam int unsigned NcrMax = 20;

    logic        clk;
    logic        arst_ni;
    logic        cmd_i;
    logic        cmd_o;
    logic        cmd_oe_o;
    logic        cmd_valid_o;
    logic [5:0]  cmd_idx_o;
    logic [31:0] cmd_arg_o;
    logic        err_o;
    logic        rsp_ready_o;
    logic        rsp_valid_i;
    logic [1:0]  rsp_type_i;
    logic [31:0] rsp_arg_i;
    logic        timeout_o;
    logic        busy_o;

    int n_checks;
    int n_errors;

    emmc_dev_cmd_responder #(
        .NCR_MIN(NcrMin),
        .NCR_MAX(NcrMax)
    ) dut (
        .clk_i      (clk),
        .arst_ni    (arst_ni),
        .cmd_i      (cmd_i),
        .cmd_o      (cmd_o),
        .cmd_oe_o   (cmd_oe_o),
        .cmd_valid_o(cmd_valid_o),
        .cmd_idx_o  (cmd_idx_o),
        .cmd_arg_o  (cmd_arg_o),
        .err_o      (err_o),
        .rsp_ready_o(rsp_ready_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_type_i (rsp_type_i),
        .rsp_arg_i  (rsp_arg_i),
        .timeout_o  (timeout_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC7, x^7 + x^3 + 1, init 0, MSB first.
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] r1_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, ref_crc7({2'b00, idx, arg}), 1'b1};
    endfunction

    // Drives a frame MSB first; returns #1 after the edge that samples the end bit.
    task automatic drive_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_i = f[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_good(input string tag, input logic [47:0] f,
                            input logic [5:0] idx, input logic [31:0] arg);
        drive_frame(f);
        check_val({tag, "_valid"}, 64'(cmd_valid_o), 64'd1);
        check_val({tag, "_err"}, 64'(err_o), 64'd0);
        check_val({tag, "_idx"}, 64'(cmd_idx_o), 64'(idx));
        check_val({tag, "_arg"}, 64'(cmd_arg_o), 64'(arg));
    endtask

    // Entered in gap cycle 1; offers the response in gap cycle acc_g.
    task automatic respond(input string tag, input int acc_g, input logic [1:0] typ,
                           input logic [31:0] arg, input logic [47:0] exp);
        int g;
        int start;
        logic oe_bad;
        logic [47:0] got;
        g = 1;
        oe_bad = 1'b0;
        while (g < acc_g) begin
            if (!rsp_ready_o || cmd_oe_o) oe_bad = 1'b1;
            @(posedge clk);
            #1;
            g++;
        end
        check_val({tag, "_ready"}, 64'(rsp_ready_o), 64'd1);
        rsp_valid_i = 1'b1;
        rsp_type_i  = typ;
        rsp_arg_i   = arg;
        @(posedge clk);
        #1;
        g++;
        rsp_valid_i = 1'b0;
        check_val({tag, "_vpulse"}, 64'(cmd_valid_o), 64'd0);
        if (typ == 2'd0 || typ == 2'd3) begin
            check_val({tag, "_none_busy"}, 64'(busy_o), 64'd0);
            check_val({tag, "_none_oe"}, 64'(cmd_oe_o | oe_bad), 64'd0);
        end else begin
            start = (NcrMin > acc_g + 1) ? NcrMin : acc_g + 1;
            while (g < start) begin
                if (cmd_oe_o) oe_bad = 1'b1;
                @(posedge clk);
                #1;
                g++;
            end
            check_val({tag, "_gap_quiet"}, 64'(oe_bad), 64'd0);
            for (int i = 47; i >= 0; i--) begin
                if (!cmd_oe_o) oe_bad = 1'b1;
                got[i] = cmd_o;
                @(posedge clk);
                #1;
            end
            check_val({tag, "_oe_on"}, 64'(oe_bad), 64'd0);
            check_val({tag, "_frame"}, 64'(got), 64'(exp));
            check_val({tag, "_oe_off"}, 64'(cmd_oe_o), 64'd0);
            check_val({tag, "_line_hi"}, 64'(cmd_o), 64'd1);
            check_val({tag, "_busy"}, 64'(busy_o), 64'd0);
        end
    endtask

    initial begin
        logic bad;
        n_checks    = 0;
        n_errors    = 0;
        arst_ni     = 1'b0;
        cmd_i       = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_type_i  = 2'd0;
        rsp_arg_i   = 32'd0;
        #23;
        check_val("rst_cmd_o", 64'(cmd_o), 64'd1);
        check_val("rst_oe", 64'(cmd_oe_o), 64'd0);
        check_val("rst_pulses", 64'({cmd_valid_o, err_o, timeout_o}), 64'd0);
        check_val("rst_ready", 64'(rsp_ready_o), 64'd0);
        check_val("rst_idx_arg", 64'({cmd_idx_o, cmd_arg_o}), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        arst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_val("idle_busy", 64'(busy_o), 64'd0);

        // Direction bit 0 aborts reception without any pulse.
        @(negedge clk);
        cmd_i = 1'b0;
        @(negedge clk);
        check_val("dir_recv_busy", 64'(busy_o), 64'd1);
        cmd_i = 1'b0;
        @(negedge clk);
        cmd_i = 1'b1;
        check_val("dir_abort_busy", 64'(busy_o), 64'd0);
        check_val("dir_abort_err", 64'(err_o), 64'd0);
        repeat (3) @(negedge clk);

        // CMD0, no response.
        cmd_good("cmd0", 48'h40_0000_0000_95, 6'd0, 32'd0);
        respond("cmd0_none", 1, 2'd0, 32'd0, 48'd0);

        // CMD17 with a flipped argument bit.
        drive_frame(48'h51_0000_0000_55 ^ (48'h1 << 20));
        check_val("crc_err_pulse", 64'(err_o), 64'd1);
        check_val("crc_err_novalid", 64'(cmd_valid_o), 64'd0);
        check_val("crc_err_idle", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        check_val("crc_err_1cyc", 64'(err_o), 64'd0);

        // CMD17 good, R1 offered in gap cycle 1.
        cmd_good("cmd17", 48'h51_0000_0000_55, 6'd17, 32'd0);
        respond("cmd17_r1", 1, 2'd1, 32'h0000_0900, r1_frame(6'd17, 32'h0000_0900));

        // CMD1, R3 offered in gap cycle 6.
        cmd_good("cmd1", host_frame(6'd1, 32'h40FF_8080), 6'd1, 32'h40FF_8080);
        respond("cmd1_r3", 6, 2'd2, 32'h80FF_8080, 48'h3F_80FF_8080_FF);

        // CMD13, R1 offered on the last allowed gap cycle.
        cmd_good("cmd13", host_frame(6'd13, 32'h0001_0000), 6'd13, 32'h0001_0000);
        respond("cmd13_late", NcrMax, 2'd1, 32'h0000_0900, r1_frame(6'd13, 32'h0000_0900));

        // Reserved response type behaves like none.
        cmd_good("cmd7", host_frame(6'd7, 32'h0001_0000), 6'd7, 32'h0001_0000);
        respond("cmd7_rsvd", 2, 2'd3, 32'h1234_5678, 48'd0);

        // No response offered: timeout.
        cmd_good("cmd9", host_frame(6'd9, 32'hABCD_0000), 6'd9, 32'hABCD_0000);
        bad = 1'b0;
        for (int g = 1; g <= NcrMax; g++) begin
            if (timeout_o || cmd_oe_o || !rsp_ready_o) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check_val("to_wait_clean", 64'(bad), 64'd0);
        check_val("to_pulse", 64'(timeout_o), 64'd1);
        check_val("to_idle", 64'(busy_o), 64'd0);
        check_val("to_ready_low", 64'(rsp_ready_o), 64'd0);
        @(posedge clk);
        #1;
        check_val("to_1cyc", 64'(timeout_o), 64'd0);

        // Reset while bit 20 of a response is on the line.
        cmd_good("cmd17b", 48'h51_0000_0000_55, 6'd17, 32'd0);
        rsp_valid_i = 1'b1;
        rsp_type_i  = 2'd1;
        rsp_arg_i   = 32'h0000_0900;
        @(posedge clk);
        #1;
        rsp_valid_i = 1'b0;
        repeat (NcrMin - 2 + 20) @(posedge clk);
        #1;
        check_val("mid_send_oe", 64'(cmd_oe_o), 64'd1);
        #2;
        arst_ni = 1'b0;
        #1;
        check_val("arst_oe", 64'(cmd_oe_o), 64'd0);
        check_val("arst_line", 64'(cmd_o), 64'd1);
        check_val("arst_busy", 64'(busy_o), 64'd0);
        check_val("arst_idx", 64'(cmd_idx_o), 64'd0);
        @(negedge clk);
        arst_ni = 1'b1;
        cmd_good("cmd0_after_rst", 48'h40_0000_0000_95, 6'd0, 32'd0);
        respond("cmd0_after_none", 1, 2'd0, 32'd0, 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
